// File: rtl/gen_obstaculos_if.sv
// gen_obstaculos_if: control, pattern-write and playfield signals of the obstacle generator.
interface gen_obstaculos_if #(
   parameter int LANES = 7,
   parameter int ROWS  = 8
);
   logic                  enable;
   logic                  step;
   logic                  mode;
   logic                  wr_en;
   logic [3:0]            wr_addr;
   logic [LANES-1:0]      wr_data;
   logic [LANES-1:0]      hero_lane;
   logic                  clr_col;
   logic [ROWS*LANES-1:0] campo;
   logic [LANES-1:0]      fila_base;
   logic                  colision;
   logic [15:0]           puntos;
   logic [3:0]            tipo_actual;
   modport master (
      output enable, step, mode, wr_en, wr_addr, wr_data, hero_lane, clr_col,
      input  campo, fila_base, colision, puntos, tipo_actual
   );
   modport slave (
      input  enable, step, mode, wr_en, wr_addr, wr_data, hero_lane, clr_col,
      output campo, fila_base, colision, puntos, tipo_actual
   );
endinterface

// File: rtl/gen_obstaculos.sv
// gen_obstaculos: programmable obstacle-pattern generator scrolling a ROWS x LANES field,
// with bottom-row collision against the hero lane and a saturating cleared-row score.
module gen_obstaculos #(
   parameter int         LANES     = 7,
   parameter int         ROWS      = 8,
   parameter int         NUM_PAT   = 10,
   parameter int         GAP       = 1,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input logic             clk,
   input logic             rst_n,
   gen_obstaculos_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;
   state_t                r_state, w_next;
   logic [ROWS*LANES-1:0] r_campo;
   logic [LANES-1:0]      r_tab [NUM_PAT];
   logic [15:0]           r_puntos;
   logic [3:0]            r_tipo, r_seq, w_idx, w_v;
   logic [2:0]            r_gap;
   logic [7:0]            r_lfsr;
   logic                  r_col, w_hit, w_go;
   logic [LANES-1:0]      w_base, w_row;

   function automatic logic [LANES-1:0] def_pat(input int i);
      logic [6:0] p;
      case (i)
         0:       p = 7'b1100011;
         1:       p = 7'b1100010;
         2:       p = 7'b1001000;
         3:       p = 7'b0001100;
         4:       p = 7'b1000010;
         5:       p = 7'b0000011;
         6:       p = 7'b0000001;
         7:       p = 7'b0001000;
         8:       p = 7'b0000101;
         9:       p = 7'b0000011;
         default: p = 7'b0;
      endcase
      return (LANES == 7) ? LANES'(p) : '0;
   endfunction

   assign w_base = r_campo[(ROWS-1)*LANES +: LANES];
   assign w_hit  = (r_state == RUN) && |(w_base & bus.hero_lane);
   assign w_go   = (r_state == RUN) && !w_hit && bus.enable && bus.step && !bus.clr_col;
   assign w_v    = r_lfsr[3:0];
   // random index folds the 4-bit LFSR value back into the used table range
   assign w_idx  = !bus.mode ? r_seq :
                   ({1'b0, w_v} >= 5'(NUM_PAT)) ? 4'({1'b0, w_v} - 5'(NUM_PAT)) : w_v;
   assign w_row  = (r_gap == 3'd0) ? r_tab[w_idx] : '0;

   always_comb begin
      w_next = r_state;
      if (bus.clr_col) w_next = IDLE;
      else if (r_state == IDLE) w_next = bus.enable ? RUN : IDLE;
      else if (r_state == RUN) w_next = w_hit ? HIT : bus.enable ? RUN : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_campo  <= '0;
         r_puntos <= '0;
         r_tipo   <= '0;
         r_seq    <= '0;
         r_gap    <= '0;
         r_col    <= 1'b0;
         r_lfsr   <= LFSR_SEED;
         for (int i = 0; i < NUM_PAT; i++) r_tab[i] <= def_pat(i);
      end else begin
         if (bus.wr_en && ({1'b0, bus.wr_addr} < 5'(NUM_PAT))) r_tab[bus.wr_addr] <= bus.wr_data;
         if (w_go) r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
         if (bus.clr_col) begin
            r_campo  <= '0;
            r_puntos <= '0;
            r_tipo   <= '0;
            r_seq    <= '0;
            r_gap    <= '0;
            r_col    <= 1'b0;
         end else begin
            if (w_hit) r_col <= 1'b1;
            if (w_go) begin
               r_campo <= {r_campo[(ROWS-1)*LANES-1:0], w_row};
               if (|w_base && r_puntos != 16'hFFFF) r_puntos <= r_puntos + 16'd1;
               r_gap <= (r_gap == 3'd0) ? 3'(GAP) : r_gap - 3'd1;
               if (r_gap == 3'd0) begin
                  r_tipo <= w_idx;
                  if (!bus.mode) r_seq <= (r_seq == 4'(NUM_PAT-1)) ? 4'd0 : r_seq + 4'd1;
               end
            end
         end
      end
   end

   assign bus.campo       = r_campo;
   assign bus.fila_base   = w_base;
   assign bus.colision    = r_col;
   assign bus.puntos      = r_puntos;
   assign bus.tipo_actual = r_tipo;
endmodule

// File: tb/tb_gen_obstaculos.sv
// tb_gen_obstaculos: directed and random checks of two gen_obstaculos instances (GAP=1, GAP=0)
// against a row-array reference model.
module tb_gen_obstaculos;
   localparam int L = 7;
   localparam int R = 8;
   localparam int NP = 10;
   localparam logic [L-1:0] DEF [NP] = '{7'b1100011, 7'b1100010, 7'b1001000, 7'b0001100,
      7'b1000010, 7'b0000011, 7'b0000001, 7'b0001000, 7'b0000101, 7'b0000011};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gen_obstaculos_if #(.LANES(L), .ROWS(R)) b0 ();
   gen_obstaculos_if #(.LANES(L), .ROWS(R)) b1 ();

   gen_obstaculos #(.GAP(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   gen_obstaculos #(.GAP(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

   assign b1.enable    = b0.enable;
   assign b1.step      = b0.step;
   assign b1.mode      = b0.mode;
   assign b1.wr_en     = b0.wr_en;
   assign b1.wr_addr   = b0.wr_addr;
   assign b1.wr_data   = b0.wr_data;
   assign b1.hero_lane = b0.hero_lane;
   assign b1.clr_col   = b0.clr_col;

   int n_chk = 0;
   int n_fail = 0;

   logic [L-1:0] m_tab [NP];
   logic [L-1:0] m_rows [2][R];
   int m_gap [2], m_seq [2], m_tipo [2], m_puntos [2], m_st [2], m_lfsr [2];
   bit m_col [2];
   int gaps [2] = '{1, 0};

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < R; r++) m_rows[k][r] = '0;
         m_gap[k] = 0; m_seq[k] = 0; m_tipo[k] = 0; m_puntos[k] = 0;
         m_st[k] = 0; m_col[k] = 0; m_lfsr[k] = 8'hA5;
      end
      for (int i = 0; i < NP; i++) m_tab[i] = DEF[i];
   endtask

   // states in the model: 0 idle, 1 run, 2 hit
   task automatic m_tick();
      for (int k = 0; k < 2; k++) begin
         int idx;
         if (b0.clr_col) begin
            for (int r = 0; r < R; r++) m_rows[k][r] = '0;
            m_col[k] = 0; m_puntos[k] = 0; m_gap[k] = 0; m_seq[k] = 0; m_tipo[k] = 0; m_st[k] = 0;
         end else if (m_st[k] == 0) m_st[k] = b0.enable ? 1 : 0;
         else if (m_st[k] == 1) begin
            if ((m_rows[k][R-1] & b0.hero_lane) != 0) begin
               m_col[k] = 1; m_st[k] = 2;
            end else if (!b0.enable) m_st[k] = 0;
            else if (b0.step) begin
               idx = b0.mode ? (m_lfsr[k] & 15) % NP : m_seq[k];
               if (m_rows[k][R-1] != 0 && m_puntos[k] < 65535) m_puntos[k]++;
               for (int r = R - 1; r > 0; r--) m_rows[k][r] = m_rows[k][r-1];
               if (m_gap[k] == 0) begin
                  m_rows[k][0] = m_tab[idx]; m_gap[k] = gaps[k]; m_tipo[k] = idx;
                  if (!b0.mode) m_seq[k] = (m_seq[k] + 1) % NP;
               end else begin
                  m_rows[k][0] = '0; m_gap[k]--;
               end
               m_lfsr[k] = ((m_lfsr[k] << 1) | ($countones(m_lfsr[k] & 8'hB8) & 1)) & 255;
            end
         end
      end
      if (b0.wr_en && b0.wr_addr < NP) m_tab[b0.wr_addr] = b0.wr_data;
   endtask

   function automatic logic [R*L-1:0] m_vec(input int k);
      logic [R*L-1:0] v;
      for (int r = 0; r < R; r++) v[r*L +: L] = m_rows[k][r];
      return v;
   endfunction

   task automatic cyc();
      m_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      b0.enable = 0; b0.step = 0; b0.mode = 0; b0.wr_en = 0; b0.wr_addr = 0;
      b0.wr_data = 0; b0.hero_lane = 0; b0.clr_col = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (b0.campo !== '0) begin n_fail++; $display("FAIL reset campo got %h exp 0", b0.campo); end
      n_chk++; if (b0.fila_base !== '0) begin n_fail++; $display("FAIL reset fila_base got %h exp 0", b0.fila_base); end
      n_chk++; if (b0.colision !== 1'b0) begin n_fail++; $display("FAIL reset colision got %b exp 0", b0.colision); end
      n_chk++; if (b0.puntos !== 16'd0) begin n_fail++; $display("FAIL reset puntos got %0d exp 0", b0.puntos); end
      n_chk++; if (b0.tipo_actual !== 4'd0) begin n_fail++; $display("FAIL reset tipo got %0d exp 0", b0.tipo_actual); end
      rst_n = 1;
      b0.step = 1;
      cyc();
      b0.step = 0;
      n_chk++; if (b1.campo !== '0) begin n_fail++; $display("FAIL idle_step campo got %h exp 0", b1.campo); end
   endtask

   task automatic test_seq();
      b0.enable = 1;
      cyc();
      b0.step = 1;
      repeat (3) cyc();
      b0.step = 0;
      n_chk++; if (b0.campo[0 +: L] !== 7'b1100010) begin n_fail++; $display("FAIL seq row0 got %b exp 1100010", b0.campo[0 +: L]); end
      n_chk++; if (b0.campo[L +: L] !== 7'b0) begin n_fail++; $display("FAIL seq row1 got %b exp 0", b0.campo[L +: L]); end
      n_chk++; if (b0.campo[2*L +: L] !== 7'b1100011) begin n_fail++; $display("FAIL seq row2 got %b exp 1100011", b0.campo[2*L +: L]); end
      n_chk++; if (b0.tipo_actual !== 4'd1) begin n_fail++; $display("FAIL seq tipo got %0d exp 1", b0.tipo_actual); end
      n_chk++; if (b1.campo !== m_vec(1)) begin n_fail++; $display("FAIL seq campo_gap0 got %h exp %h", b1.campo, m_vec(1)); end
   endtask

   task automatic test_wrap();
      b0.clr_col = 1;
      cyc();
      b0.clr_col = 0;
      cyc();
      b0.step = 1;
      repeat (11) cyc();
      b0.step = 0;
      n_chk++; if (b1.campo[0 +: L] !== 7'b1100011) begin n_fail++; $display("FAIL wrap row0 got %b exp 1100011", b1.campo[0 +: L]); end
      n_chk++; if (b1.campo[L +: L] !== 7'b0000011) begin n_fail++; $display("FAIL wrap row1 got %b exp 0000011", b1.campo[L +: L]); end
      n_chk++; if (b1.tipo_actual !== 4'd0) begin n_fail++; $display("FAIL wrap tipo got %0d exp 0", b1.tipo_actual); end
      n_chk++; if (b1.puntos !== 16'd3) begin n_fail++; $display("FAIL wrap puntos_gap0 got %0d exp 3", b1.puntos); end
      n_chk++; if (b0.puntos !== 16'd2) begin n_fail++; $display("FAIL wrap puntos_gap1 got %0d exp 2", b0.puntos); end
      n_chk++; if (b0.campo !== m_vec(0)) begin n_fail++; $display("FAIL wrap campo_gap1 got %h exp %h", b0.campo, m_vec(0)); end
   endtask

   task automatic test_collision();
      logic [R*L-1:0] held;
      b0.clr_col = 1;
      cyc();
      b0.clr_col = 0;
      cyc();
      b0.hero_lane = 7'b0000001;
      b0.step = 1;
      repeat (8) cyc();
      b0.step = 0;
      n_chk++; if (b0.fila_base !== 7'b1100011) begin n_fail++; $display("FAIL col fila_base got %b exp 1100011", b0.fila_base); end
      n_chk++; if (b0.colision !== 1'b0) begin n_fail++; $display("FAIL col early got %b exp 0", b0.colision); end
      cyc();
      n_chk++; if (b0.colision !== 1'b1) begin n_fail++; $display("FAIL col set got %b exp 1", b0.colision); end
      n_chk++; if (b1.colision !== 1'b1) begin n_fail++; $display("FAIL col set_gap0 got %b exp 1", b1.colision); end
      held = b0.campo;
      b0.step = 1;
      repeat (3) cyc();
      b0.step = 0;
      n_chk++; if (b0.campo !== m_vec(0)) begin n_fail++; $display("FAIL col frozen got %h exp %h", b0.campo, m_vec(0)); end
      n_chk++; if (b0.tipo_actual !== 4'd3) begin n_fail++; $display("FAIL col tipo got %0d exp 3", b0.tipo_actual); end
      b0.clr_col = 1;
      cyc();
      b0.clr_col = 0;
      n_chk++; if (b0.campo !== '0) begin n_fail++; $display("FAIL clr campo got %h exp 0 (was %h)", b0.campo, held); end
      n_chk++; if (b0.colision !== 1'b0) begin n_fail++; $display("FAIL clr colision got %b exp 0", b0.colision); end
      n_chk++; if (b0.tipo_actual !== 4'd0) begin n_fail++; $display("FAIL clr tipo got %0d exp 0", b0.tipo_actual); end
      b0.step = 1;
      cyc();
      b0.step = 0;
      n_chk++; if (b0.campo !== '0) begin n_fail++; $display("FAIL clr idle_step got %h exp 0", b0.campo); end
      b0.hero_lane = 0;
   endtask

   task automatic test_write();
      b0.clr_col = 1;
      cyc();
      b0.clr_col = 0;
      b0.wr_en = 1; b0.wr_addr = 0; b0.wr_data = 7'b0;
      cyc();
      b0.wr_addr = 12; b0.wr_data = 7'b1111111;
      cyc();
      b0.wr_en = 0;
      b0.step = 1;
      repeat (8) cyc();
      n_chk++; if (b0.fila_base !== 7'b0) begin n_fail++; $display("FAIL wr fila_base got %b exp 0", b0.fila_base); end
      cyc();
      n_chk++; if (b0.puntos !== 16'd0) begin n_fail++; $display("FAIL wr puntos9 got %0d exp 0", b0.puntos); end
      repeat (2) cyc();
      b0.step = 0;
      n_chk++; if (b0.puntos !== 16'd1) begin n_fail++; $display("FAIL wr puntos11 got %0d exp 1", b0.puntos); end
      n_chk++; if (b1.puntos !== m_puntos[1]) begin n_fail++; $display("FAIL wr puntos_gap0 got %0d exp %0d", b1.puntos, m_puntos[1]); end
      n_chk++; if (b1.campo !== m_vec(1)) begin n_fail++; $display("FAIL wr campo_gap0 got %h exp %h", b1.campo, m_vec(1)); end
   endtask

   task automatic test_async_reset();
      #2;
      rst_n = 0;
      #1;
      n_chk++; if (b0.campo !== '0) begin n_fail++; $display("FAIL areset campo got %h exp 0", b0.campo); end
      n_chk++; if (b0.fila_base !== '0) begin n_fail++; $display("FAIL areset fila_base got %h exp 0", b0.fila_base); end
      n_chk++; if (b0.puntos !== 16'd0) begin n_fail++; $display("FAIL areset puntos got %0d exp 0", b0.puntos); end
      n_chk++; if (b0.tipo_actual !== 4'd0) begin n_fail++; $display("FAIL areset tipo got %0d exp 0", b0.tipo_actual); end
      m_reset();
      @(posedge clk);
      #1;
      rst_n = 1;
      cyc();
      b0.step = 1;
      cyc();
      b0.step = 0;
      n_chk++; if (b0.campo[0 +: L] !== 7'b1100011) begin n_fail++; $display("FAIL areset table0 got %b exp 1100011", b0.campo[0 +: L]); end
   endtask

   task automatic test_random();
      int acc = 0;
      b0.mode = 1;
      cyc();
      for (int c = 0; c < 200 && acc < 20; c++) begin
         b0.step = 1'($urandom_range(0, 1));
         if (b0.step) acc++;
         cyc();
         n_chk++; if (b0.campo !== m_vec(0)) begin n_fail++; $display("FAIL rnd campo c%0d got %h exp %h", c, b0.campo, m_vec(0)); end
         n_chk++; if (b1.campo !== m_vec(1)) begin n_fail++; $display("FAIL rnd campo_gap0 c%0d got %h exp %h", c, b1.campo, m_vec(1)); end
         n_chk++; if (b0.tipo_actual !== 4'(m_tipo[0]) || b0.tipo_actual >= NP) begin n_fail++; $display("FAIL rnd tipo c%0d got %0d exp %0d", c, b0.tipo_actual, m_tipo[0]); end
         n_chk++; if (b1.tipo_actual !== 4'(m_tipo[1])) begin n_fail++; $display("FAIL rnd tipo_gap0 c%0d got %0d exp %0d", c, b1.tipo_actual, m_tipo[1]); end
         n_chk++; if (b0.puntos !== 16'(m_puntos[0])) begin n_fail++; $display("FAIL rnd puntos c%0d got %0d exp %0d", c, b0.puntos, m_puntos[0]); end
      end
      n_chk++; if (acc < 20) begin n_fail++; $display("FAIL rnd step_budget got %0d exp 20", acc); end
      for (int c = 0; c < 400; c++) begin
         b0.enable = ($urandom_range(0, 7) != 0);
         b0.step = 1'($urandom_range(0, 1));
         b0.mode = 1'($urandom_range(0, 1));
         b0.clr_col = ($urandom_range(0, 15) == 0);
         b0.hero_lane = ($urandom_range(0, 3) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'b0;
         b0.wr_en = ($urandom_range(0, 7) == 0);
         b0.wr_addr = 4'($urandom_range(0, 15));
         b0.wr_data = 7'($urandom);
         cyc();
         n_chk++; if (b0.campo !== m_vec(0)) begin n_fail++; $display("FAIL mix campo c%0d got %h exp %h", c, b0.campo, m_vec(0)); end
         n_chk++; if (b1.campo !== m_vec(1)) begin n_fail++; $display("FAIL mix campo_gap0 c%0d got %h exp %h", c, b1.campo, m_vec(1)); end
         n_chk++; if (b0.colision !== m_col[0] || b1.colision !== m_col[1]) begin n_fail++; $display("FAIL mix colision c%0d got %b%b exp %b%b", c, b0.colision, b1.colision, m_col[0], m_col[1]); end
         n_chk++; if (b0.puntos !== 16'(m_puntos[0]) || b1.puntos !== 16'(m_puntos[1])) begin n_fail++; $display("FAIL mix puntos c%0d got %0d/%0d exp %0d/%0d", c, b0.puntos, b1.puntos, m_puntos[0], m_puntos[1]); end
         n_chk++; if (b0.tipo_actual !== 4'(m_tipo[0]) || b1.tipo_actual !== 4'(m_tipo[1])) begin n_fail++; $display("FAIL mix tipo c%0d got %0d/%0d exp %0d/%0d", c, b0.tipo_actual, b1.tipo_actual, m_tipo[0], m_tipo[1]); end
      end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_wrap();
      test_collision();
      test_write();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
